fir_pipe_sat: RTL and testbench
===============================

Name: fir_pipe_sat

Overview:
- Parametrised, pipelined direct-form FIR filter with a fixed 2-edge latency and a valid handshake.
- Generalises the fixed 4-tap FIR to N_TAPS taps with a run-time writable coefficient bank, a configurable output scaling shift, and saturation with a sticky flag.
- Sits between the sample source and downstream DSP in the TP2 datapath.
- Samples arrive on a valid strobe; gaps are allowed.

Parameters:
- NB_DATA, 16: sample and output width, signed two's complement.
- NB_COEF, 16: coefficient width, signed.
- N_TAPS, 8: number of taps, at least 2.
- SHIFT, 15: arithmetic right shift applied to the accumulator before saturation, 0 to NB_DATA+NB_COEF-2.

Ports:
- i_clk, in, 1: clock. All registers are on the rising edge.
- i_rst, in, 1: asynchronous active-high reset.
- i_valid, in, 1: i_data carries a new sample this cycle.
- i_data, in, NB_DATA: input sample, signed.
- i_clear, in, 1: synchronous flush of the delay line and the pipeline. Coefficients are kept.
- i_coef_we, in, 1: coefficient write strobe.
- i_coef_addr, in, clog2(N_TAPS): tap index for the write.
- i_coef_data, in, NB_COEF: coefficient value, signed.
- o_valid, out, 1: o_data is a new filter output this cycle.
- o_data, out, NB_DATA: saturated filter output, signed.
- o_sat, out, 1: set when the output associated with o_valid was clipped.
- o_sat_sticky, out, 1: OR of all o_sat since the last reset or clear.

Behaviour:
- **Reset (async, i_rst=1):**
  - Delay line x[0..N_TAPS-2], coefficient bank h[0..N_TAPS-1] and product registers are 0.
  - o_valid=0, o_data=0, o_sat=0, o_sat_sticky=0.
  - Release is synchronous to the next edge.
- **Stage 1, edge k with i_valid=1:**
  - The window is w[0]=i_data, w[j]=x[j-1].
  - The product register p[j] captures w[j]*h[j] at full NB_DATA+NB_COEF width, using the coefficient values held before edge k.
  - The delay line shifts: x[0]<=i_data, x[j]<=x[j-1].
  - An internal flag v1<=1.
- **Stage 1, edge k with i_valid=0:** the delay line and p hold, and v1<=0.
- **Stage 2, edge k+1:**
  - acc = signed sum of all p[j], with width NB_ACC = NB_DATA+NB_COEF+clog2(N_TAPS). No intermediate wrap is allowed.
  - s = acc >>> SHIFT (floor, no rounding).
  - If s > 2^(NB_DATA-1)-1, o_data = 0x7FFF-style max and o_sat=1.
  - If s < -2^(NB_DATA-1), o_data = min and o_sat=1.
  - Otherwise o_data = s[NB_DATA-1:0] and o_sat=0.
  - o_valid<=v1.
- **Latency:** o_valid is high in the cycle after edge k+1, i.e. a 2-edge latency. Throughput is one sample per clock.
- **Output hold when no new data:** when o_valid=0, o_data holds its last value and o_sat is 0.
- **Sticky flag:** o_sat_sticky<=o_sat_sticky | (new o_sat & o_valid).
- **Coefficient write:** at an edge with i_coef_we=1, h[i_coef_addr]<=i_coef_data.
  - A write at the same edge as an accepted sample does not affect that sample; it affects samples accepted at later edges.
  - An out-of-range address (N_TAPS not a power of 2) is ignored.
- **i_clear=1:**
  - At the edge, the delay line, p, v1, o_valid, o_sat and o_sat_sticky go to 0.
  - i_valid is ignored that cycle.
  - h is unchanged and o_data holds.
- **Priority:** i_rst > i_clear > i_valid. A coefficient write is independent of i_clear.
- **Reset mid-operation:** in-flight samples are discarded and no o_valid pulse is produced.

Test Plan:
1. **Impulse response.** N_TAPS=4, SHIFT=0, h={3,4,5,6}; feed 1,0,0,0,0 with i_valid=1 continuously -> o_data=3,4,5,6,0. First o_valid 2 edges after the first sample.
2. **Valid gaps.** Same setup; i_valid pattern 1,0,0,1,0,1 with data 1,x,x,0,x,0 -> exactly 3 o_valid pulses with values 3,4,5; o_data holds between pulses.
3. **Positive and negative saturation.** SHIFT=15, all h=0x7FFF.
   - Drive 0x7FFF for 4 samples -> 4th output 0x7FFF with o_sat=1 and o_sat_sticky=1.
   - Then drive 0x8000 for 4 samples -> 0x8000 with o_sat=1.
4. **Coefficient write on a sample edge.** Write h[0]=10 at the same edge as accepting sample 1 -> that output uses the old h[0]=3; the next impulse gives 10.
5. **Clear.** Mid-stream i_clear pulse -> no o_valid for in-flight samples, sticky cleared; the following impulse reproduces {3,4,5,6} unchanged.
6. **Async reset.** Assert i_rst asynchronously between edges while o_valid=1 -> all outputs 0 immediately; after release, outputs stay 0 because h=0.

Source files
------------

// File: rtl/fir_pipe_sat.sv
// Pipelined direct-form FIR: a product stage, then a sum/shift/saturate stage.
// The coefficient bank can be rewritten at run time, and saturation sets a sticky flag.
module fir_pipe_sat #(
    parameter int unsigned NB_DATA = 16,
    parameter int unsigned NB_COEF = 16,
    parameter int unsigned N_TAPS  = 8,
    parameter int unsigned SHIFT   = 15,
    localparam int unsigned NB_ADDR = $clog2(N_TAPS)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_clear,
    input  logic               i_coef_we,
    input  logic [NB_ADDR-1:0] i_coef_addr,
    input  logic [NB_COEF-1:0] i_coef_data,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_sat,
    output logic               o_sat_sticky
);

    localparam int unsigned NB_PROD = NB_DATA + NB_COEF;
    localparam int unsigned NB_ACC  = NB_PROD + NB_ADDR;

    // Output range limits, sign-extended to accumulator width for signed compares.
    localparam logic signed [NB_ACC-1:0] ACC_MAX =
        {{(NB_ACC-NB_DATA+1){1'b0}}, {(NB_DATA-1){1'b1}}};
    localparam logic signed [NB_ACC-1:0] ACC_MIN =
        {{(NB_ACC-NB_DATA+1){1'b1}}, {(NB_DATA-1){1'b0}}};
    localparam logic [NB_DATA-1:0] DATA_MAX = {1'b0, {(NB_DATA-1){1'b1}}};
    localparam logic [NB_DATA-1:0] DATA_MIN = {1'b1, {(NB_DATA-1){1'b0}}};

    logic signed [NB_DATA-1:0] x_q [N_TAPS-1];
    logic signed [NB_DATA-1:0] x_d [N_TAPS-1];
    logic signed [NB_COEF-1:0] h_q [N_TAPS];
    logic signed [NB_COEF-1:0] h_d [N_TAPS];
    logic signed [NB_PROD-1:0] p_q [N_TAPS];
    logic signed [NB_PROD-1:0] p_d [N_TAPS];
    logic signed [NB_DATA-1:0] w   [N_TAPS];

    logic               v1_q, v1_d;
    logic               o_valid_q, o_valid_d;
    logic [NB_DATA-1:0] o_data_q, o_data_d;
    logic               o_sat_q, o_sat_d;
    logic               o_sat_sticky_q, o_sat_sticky_d;

    logic signed [NB_ACC-1:0] acc;
    logic signed [NB_ACC-1:0] shifted;
    logic [NB_DATA-1:0]       sat_data;
    logic                     sat_flag;

    // Filter window: the incoming sample followed by the delay line.
    always_comb begin
        w[0] = i_data;
        for (int unsigned j = 1; j < N_TAPS; j++) begin
            w[j] = x_q[j-1];
        end
    end

    // Stage 1: capture products and shift the delay line on an accepted sample.
    always_comb begin
        x_d  = x_q;
        p_d  = p_q;
        v1_d = 1'b0;
        if (i_clear) begin
            for (int unsigned j = 0; j < N_TAPS - 1; j++) begin
                x_d[j] = '0;
            end
            for (int unsigned j = 0; j < N_TAPS; j++) begin
                p_d[j] = '0;
            end
        end else if (i_valid) begin
            for (int unsigned j = 0; j < N_TAPS; j++) begin
                p_d[j] = NB_PROD'(w[j]) * NB_PROD'(h_q[j]);
            end
            x_d[0] = i_data;
            for (int unsigned j = 1; j < N_TAPS - 1; j++) begin
                x_d[j] = x_q[j-1];
            end
            v1_d = 1'b1;
        end
    end

    // Coefficient bank write; products above use the pre-write values.
    always_comb begin
        h_d = h_q;
        if (i_coef_we && (32'(i_coef_addr) < N_TAPS)) begin
            h_d[i_coef_addr] = i_coef_data;
        end
    end

    // Stage 2 datapath: full-width sum, floor shift, clip to output range.
    always_comb begin
        acc = '0;
        for (int unsigned j = 0; j < N_TAPS; j++) begin
            acc = acc + NB_ACC'(p_q[j]);
        end
        shifted = acc >>> SHIFT;
        if (shifted > ACC_MAX) begin
            sat_data = DATA_MAX;
            sat_flag = 1'b1;
        end else if (shifted < ACC_MIN) begin
            sat_data = DATA_MIN;
            sat_flag = 1'b1;
        end else begin
            sat_data = shifted[NB_DATA-1:0];
            sat_flag = 1'b0;
        end
    end

    // Stage 2 output registers; o_data holds when there is no new result.
    always_comb begin
        o_valid_d      = 1'b0;
        o_data_d       = o_data_q;
        o_sat_d        = 1'b0;
        o_sat_sticky_d = o_sat_sticky_q;
        if (i_clear) begin
            o_sat_sticky_d = 1'b0;
        end else begin
            o_valid_d = v1_q;
            if (v1_q) begin
                o_data_d = sat_data;
                o_sat_d  = sat_flag;
            end
            o_sat_sticky_d = o_sat_sticky_q | (o_sat_d & o_valid_d);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned j = 0; j < N_TAPS - 1; j++) begin
                x_q[j] <= '0;
            end
            for (int unsigned j = 0; j < N_TAPS; j++) begin
                h_q[j] <= '0;
                p_q[j] <= '0;
            end
            v1_q           <= 1'b0;
            o_valid_q      <= 1'b0;
            o_data_q       <= '0;
            o_sat_q        <= 1'b0;
            o_sat_sticky_q <= 1'b0;
        end else begin
            x_q            <= x_d;
            h_q            <= h_d;
            p_q            <= p_d;
            v1_q           <= v1_d;
            o_valid_q      <= o_valid_d;
            o_data_q       <= o_data_d;
            o_sat_q        <= o_sat_d;
            o_sat_sticky_q <= o_sat_sticky_d;
        end
    end

    assign o_valid      = o_valid_q;
    assign o_data       = o_data_q;
    assign o_sat        = o_sat_q;
    assign o_sat_sticky = o_sat_sticky_q;

endmodule

// File: tb/tb_fir_pipe_sat.sv
// Bench for fir_pipe_sat: two 4-tap instances (SHIFT 0 and 15) share stimulus;
// a transaction-level model pushes expected outputs into a queue at each accepted sample.
module tb_fir_pipe_sat;

    localparam int NT  = 4;
    localparam int SH0 = 0;
    localparam int SH1 = 15;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_data;
    logic        i_clear;
    logic        i_coef_we;
    logic [1:0]  i_coef_addr;
    logic [15:0] i_coef_data;

    logic        o_valid0, o_sat0, o_sticky0;
    logic [15:0] o_data0;
    logic        o_valid1, o_sat1, o_sticky1;
    logic [15:0] o_data1;

    fir_pipe_sat #(.NB_DATA(16), .NB_COEF(16), .N_TAPS(NT), .SHIFT(SH0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_data(i_data),
        .i_clear(i_clear), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
        .i_coef_data(i_coef_data), .o_valid(o_valid0), .o_data(o_data0),
        .o_sat(o_sat0), .o_sat_sticky(o_sticky0)
    );

    fir_pipe_sat #(.NB_DATA(16), .NB_COEF(16), .N_TAPS(NT), .SHIFT(SH1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_data(i_data),
        .i_clear(i_clear), .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr),
        .i_coef_data(i_coef_data), .o_valid(o_valid1), .o_data(o_data1),
        .o_sat(o_sat1), .o_sat_sticky(o_sticky1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d0;
        logic        s0;
        logic [15:0] d1;
        logic        s1;
    } exp_t;

    exp_t   q[$];
    longint xm[NT-1];
    longint hm[NT];
    logic   v1_m, ov_m;
    logic [15:0] ld0, ld1;
    logic   st0, st1;
    int     n_vec;
    int     n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sat_fn(input longint acc, input int sh, output logic [15:0] dq, output logic s);
        longint v;
        v = acc >>> sh;
        if (v > 64'sd32767) begin
            dq = 16'h7fff; s = 1'b1;
        end else if (v < -64'sd32768) begin
            dq = 16'h8000; s = 1'b1;
        end else begin
            dq = v[15:0]; s = 1'b0;
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < NT - 1; j++) xm[j] = 0;
        for (int j = 0; j < NT; j++) hm[j] = 0;
        q.delete();
        v1_m = 1'b0; ov_m = 1'b0;
        ld0 = 16'h0; ld1 = 16'h0;
        st0 = 1'b0; st1 = 1'b0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input logic v, input logic [15:0] d, input logic clr,
                              input logic we, input logic [1:0] a, input logic [15:0] cd);
        longint w[NT];
        longint acc;
        exp_t   e;
        if (clr) begin
            ov_m = 1'b0; v1_m = 1'b0;
            for (int j = 0; j < NT - 1; j++) xm[j] = 0;
            q.delete();
            st0 = 1'b0; st1 = 1'b0;
        end else begin
            ov_m = v1_m;
            v1_m = v;
            if (v) begin
                w[0] = longint'($signed(d));
                for (int j = 1; j < NT; j++) w[j] = xm[j-1];
                acc = 0;
                for (int j = 0; j < NT; j++) acc += w[j] * hm[j];
                sat_fn(acc, SH0, e.d0, e.s0);
                sat_fn(acc, SH1, e.d1, e.s1);
                q.push_back(e);
                for (int j = NT - 2; j > 0; j--) xm[j] = xm[j-1];
                xm[0] = w[0];
            end
        end
        if (we) hm[a] = longint'($signed(cd));
    endtask

    // Compare both instances against the model state after the last edge.
    task automatic check_outputs();
        exp_t e;
        logic es0, es1;
        es0 = 1'b0; es1 = 1'b0;
        if (ov_m) begin
            check("queue_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                ld0 = e.d0; ld1 = e.d1;
                es0 = e.s0; es1 = e.s1;
                st0 = st0 | es0; st1 = st1 | es1;
            end
        end
        check("valid0",  32'(o_valid0),  32'(ov_m));
        check("data0",   32'(o_data0),   32'(ld0));
        check("sat0",    32'(o_sat0),    32'(es0));
        check("sticky0", 32'(o_sticky0), 32'(st0));
        check("valid1",  32'(o_valid1),  32'(ov_m));
        check("data1",   32'(o_data1),   32'(ld1));
        check("sat1",    32'(o_sat1),    32'(es1));
        check("sticky1", 32'(o_sticky1), 32'(st1));
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic clr,
                        input logic we, input logic [1:0] a, input logic [15:0] cd);
        @(negedge clk);
        check_outputs();
        i_valid = v; i_data = d; i_clear = clr;
        i_coef_we = we; i_coef_addr = a; i_coef_data = cd;
        model_edge(v, d, clr, we, a, cd);
    endtask

    task automatic smp(input logic [15:0] d);
        step(1'b1, d, 1'b0, 1'b0, 2'd0, 16'h0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] cd);
        step(1'b0, 16'(($urandom)), 1'b0, 1'b1, a, cd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'(($urandom)), 1'b0, 1'b0, 2'd0, 16'h0);
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b1;
        i_valid = 1'b0; i_data = 16'h0; i_clear = 1'b0;
        i_coef_we = 1'b0; i_coef_addr = 2'd0; i_coef_data = 16'h0;
        model_reset();

        // Reset state
        @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Impulse response: h = {3,4,5,6} -> 3,4,5,6,0
        wr(2'd0, 16'd3); wr(2'd1, 16'd4); wr(2'd2, 16'd5); wr(2'd3, 16'd6);
        smp(16'd1);
        for (int i = 0; i < 4; i++) smp(16'd0);
        idle(3);

        // Valid gaps: three pulses 3,4,5 with o_data holding between them
        step(1'b1, 16'd1, 1'b0, 1'b0, 2'd0, 16'h0);
        step(1'b0, 16'(($urandom)), 1'b0, 1'b0, 2'd0, 16'h0);
        step(1'b0, 16'(($urandom)), 1'b0, 1'b0, 2'd0, 16'h0);
        step(1'b1, 16'd0, 1'b0, 1'b0, 2'd0, 16'h0);
        step(1'b0, 16'(($urandom)), 1'b0, 1'b0, 2'd0, 16'h0);
        step(1'b1, 16'd0, 1'b0, 1'b0, 2'd0, 16'h0);
        idle(3);

        // Positive then negative saturation with all h = 0x7FFF
        for (int i = 0; i < NT; i++) wr(2'(i), 16'h7fff);
        for (int i = 0; i < 4; i++) smp(16'h7fff);
        for (int i = 0; i < 4; i++) smp(16'h8000);
        idle(3);

        // Clear mid-stream: in-flight output dropped, sticky cleared,
        // coefficient write at the clear edge still lands (h[0] = 10)
        wr(2'd0, 16'd3); wr(2'd1, 16'd4); wr(2'd2, 16'd5); wr(2'd3, 16'd6);
        smp(16'd1);
        smp(16'd7);
        step(1'b1, 16'd5, 1'b1, 1'b1, 2'd0, 16'd10);
        smp(16'd1);
        for (int i = 0; i < 3; i++) smp(16'd0);
        idle(3);

        // Coefficient write on a sample edge: h[0]=3 affects only later samples
        step(1'b1, 16'd1, 1'b0, 1'b1, 2'd0, 16'd3);
        for (int i = 0; i < 3; i++) smp(16'd0);
        smp(16'd1);
        for (int i = 0; i < 3; i++) smp(16'd0);
        idle(3);

        // Negative small values exercise floor shift in the SHIFT=15 instance
        smp(16'hffff);
        smp(16'hfff0);
        idle(3);

        // Async reset between edges while o_valid is high
        smp(16'd1);
        smp(16'd0);
        @(negedge clk);
        check_outputs();
        check("ov_before_reset", 32'(o_valid0), 32'd1);
        i_valid = 1'b0; i_data = 16'h0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        smp(16'd1); smp(16'd2); smp(16'd3);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
